// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg : AHB-Lite encodings and slave FSM state type                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } slave_state_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
    function automatic logic is_active(input logic [1:0] htrans);
        logic r;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_sram_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_sram_slave_if : AHB-Lite single-slave bus signal bundle      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ahb_lite_sram_slave_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        output HWDATA,
        input  HRDATA,
        input  HREADY,
        input  HRESP
    );

    modport slave (
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        input  HWDATA,
        output HRDATA,
        output HREADY,
        output HRESP
    );

endinterface
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_sram_array : DEPTH x 32 single-port RAM, sync write, async read   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_sram_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_sram_slave : AHB-Lite SRAM slave with wait states and        |
// |                       two-cycle ERROR response for illegal transfers  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_sram_slave_if.slave  bus
);

    localparam int unsigned c_AW        = $clog2(MEM_DEPTH);
    localparam logic [2:0]  c_WAIT_LOAD = 3'(WAIT_STATES);

    if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("ahb_lite_sram_slave: MEM_DEPTH must be a power of 2");
    end
    if (WAIT_STATES > 7) begin : g_chk_wait
        $error("ahb_lite_sram_slave: WAIT_STATES must be in 0..7");
    end
    if ((BASE_ADDR % (4 * MEM_DEPTH)) != 0) begin : g_chk_base
        $error("ahb_lite_sram_slave: BASE_ADDR must be aligned to 4*MEM_DEPTH");
    end

    slave_state_t    r_state;
    slave_state_t    w_state_nxt;
    logic [2:0]      r_wcnt;
    logic [2:0]      w_wcnt_nxt;
    logic [c_AW-1:0] r_idx;
    logic            r_write;

    logic [32:0]     w_offset;
    logic [c_AW-1:0] w_idx;
    logic            w_err;
    logic            w_addr_ok;
    logic            w_accept;
    logic            w_hready;
    logic            w_hresp;
    logic            w_we;
    logic [31:0]     w_mem_rdata;

    // Offset carries a borrow bit, so one subtraction covers both range bounds.
    assign w_offset = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
    assign w_idx    = w_offset[c_AW+1:2];
    assign w_err    = (bus.HSIZE != HSIZE_WORD)
                   || (w_offset[1:0] != 2'b00)
                   || w_offset[32]
                   || (w_offset[31:c_AW+2] != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_hready    = 1'b1;
        w_hresp     = HRESP_OKAY;
        w_addr_ok   = 1'b0;
        w_accept    = 1'b0;

        case (r_state)
            IDLE, DATA: begin
                w_addr_ok = 1'b1;
            end
            WAIT: begin
                w_hready   = 1'b0;
                w_wcnt_nxt = r_wcnt - 3'd1;
                if (r_wcnt == 3'd1) begin
                    w_state_nxt = DATA;
                end
            end
            ERR1: begin
                w_hready    = 1'b0;
                w_hresp     = HRESP_ERROR;
                w_state_nxt = ERR2;
            end
            ERR2: begin
                w_hresp   = HRESP_ERROR;
                w_addr_ok = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Any state that completes its data phase evaluates the next address phase.
        if (w_addr_ok) begin
            w_accept = is_active(bus.HTRANS);
            if (!w_accept) begin
                w_state_nxt = IDLE;
            end else if (w_err) begin
                w_state_nxt = ERR1;
            end else if (WAIT_STATES == 0) begin
                w_state_nxt = DATA;
            end else begin
                w_state_nxt = WAIT;
                w_wcnt_nxt  = c_WAIT_LOAD;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= IDLE;
            r_wcnt  <= 3'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_write <= bus.HWRITE;
            end
        end
    end

    // Gating on HRESETn aborts a write whose final edge coincides with reset.
    assign w_we = HRESETn && (r_state == DATA) && r_write;

    ahb_sram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (c_AW)
    ) u_array (
        .clk     (HCLK),
        .i_we    (w_we),
        .i_idx   (r_idx),
        .i_wdata (bus.HWDATA),
        .o_rdata (w_mem_rdata)
    );

    // Read data is only presented for the completing cycle of a read.
    assign bus.HRDATA = ((r_state == DATA) && !r_write) ? w_mem_rdata : 32'h0;
    assign bus.HREADY = w_hready;
    assign bus.HRESP  = w_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_lite_sram_slave : directed bench, WAIT_STATES=0 and =3 slaves  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ahb_lite_sram_slave;
    import ahb_pkg::*;

    localparam int unsigned MEM_DEPTH = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic [31:0] xdata  [2];
    logic [31:0] rd_o   [2];
    logic        rdy_o  [2];
    logic        rsp_o  [2];

    ahb_lite_sram_slave_if bus0 ();
    ahb_lite_sram_slave_if bus1 ();

    assign bus0.HADDR  = haddr[0];
    assign bus0.HTRANS = htrans[0];
    assign bus0.HWRITE = hwrite[0];
    assign bus0.HSIZE  = hsize[0];
    assign bus0.HWDATA = hwdata[0];
    assign rd_o[0]     = bus0.HRDATA;
    assign rdy_o[0]    = bus0.HREADY;
    assign rsp_o[0]    = bus0.HRESP;

    assign bus1.HADDR  = haddr[1];
    assign bus1.HTRANS = htrans[1];
    assign bus1.HWRITE = hwrite[1];
    assign bus1.HSIZE  = hsize[1];
    assign bus1.HWDATA = hwdata[1];
    assign rd_o[1]     = bus1.HRDATA;
    assign rdy_o[1]    = bus1.HREADY;
    assign rsp_o[1]    = bus1.HRESP;

    ahb_lite_sram_slave #(
        .MEM_DEPTH   (MEM_DEPTH),
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_STATES (0)
    ) u_dut0 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus0)
    );

    ahb_lite_sram_slave #(
        .MEM_DEPTH   (MEM_DEPTH),
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_STATES (3)
    ) u_dut1 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus1)
    );

    // One expected data-phase cycle: kind 0 = none, 1 = read completes, 2 = write completes.
    typedef struct {
        bit          ready;
        bit          resp;
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ph_t;

    ph_t         q [2][$];
    logic [31:0] mmem [bit [32:0]];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    int          lowrun  [2];
    int          lastrun [2];
    int          errcyc  [2];
    int          lowcyc  [2];
    logic [31:0] obs_rd  [2];
    logic [31:0] exp_rd;

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    function automatic bit addr_err(input logic [31:0] a, input logic [2:0] sz);
        longint unsigned la;
        longint unsigned lo;
        longint unsigned hi;
        la = longint'(a);
        lo = longint'(BASE_ADDR);
        hi = lo + 4 * MEM_DEPTH;
        return (sz != 3'b010) || (a[1:0] != 2'b00) || (la < lo) || (la >= hi);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < 2; s++) begin
                ph_t e;
                e = '{1'b1, 1'b0, 0, 32'h0, 32'h0};
                if (q[s].size() > 0) begin
                    e = q[s].pop_front();
                end
                exp_rd = (e.kind == 1) ? mmem[{s[0], e.addr}] : 32'h0;
                chk($sformatf("dut%0d HREADY", s), {31'b0, rdy_o[s]}, {31'b0, e.ready});
                chk($sformatf("dut%0d HRESP", s), {31'b0, rsp_o[s]}, {31'b0, e.resp});
                if (e.kind != 2) begin
                    chk($sformatf("dut%0d HRDATA", s), rd_o[s], exp_rd);
                end
                if (e.kind == 1) begin
                    obs_rd[s] = rd_o[s];
                end
                if (rdy_o[s] === 1'b0) begin
                    lowrun[s]++;
                    lowcyc[s]++;
                end else begin
                    if (lowrun[s] > 0) lastrun[s] = lowrun[s];
                    lowrun[s] = 0;
                end
                if (rsp_o[s] === 1'b1) errcyc[s]++;

                if (e.kind == 2 && rst_n) begin
                    mmem[{s[0], e.addr}] = e.data;
                end
                if (!rst_n) begin
                    q[s].delete();
                end else if (e.ready && htrans[s][1]) begin
                    if (addr_err(haddr[s], hsize[s])) begin
                        q[s].push_back('{1'b0, 1'b1, 0, 32'h0, 32'h0});
                        q[s].push_back('{1'b1, 1'b1, 0, 32'h0, 32'h0});
                    end else begin
                        for (int w = 0; w < ws_of(s); w++) begin
                            q[s].push_back('{1'b0, 1'b0, 0, 32'h0, 32'h0});
                        end
                        q[s].push_back('{1'b1, 1'b0, hwrite[s] ? 2 : 1, haddr[s], xdata[s]});
                    end
                end
            end
        end
    end

    task automatic issue(input int s, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz, input logic [31:0] d);
        bit ok;
        ok        = 1'b0;
        htrans[s] = tr;
        haddr[s]  = a;
        hwrite[s] = wr;
        hsize[s]  = sz;
        xdata[s]  = d;
        for (int i = 0; i < 32 && !ok; i++) begin
            @(negedge clk);
            if (rdy_o[s] === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dut%0d accept timeout: HREADY got 0 expected 1 within 32 cycles", s);
        end
        @(posedge clk);
        #1;
        hwdata[s] = d;
    endtask

    task automatic idle(input int s, input int n);
        htrans[s] = HTRANS_IDLE;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            haddr[s]   = 32'h0;
            htrans[s]  = HTRANS_IDLE;
            hwrite[s]  = 1'b0;
            hsize[s]   = HSIZE_WORD;
            hwdata[s]  = 32'h0;
            xdata[s]   = 32'h0;
            lowrun[s]  = 0;
            lastrun[s] = 0;
            errcyc[s]  = 0;
            lowcyc[s]  = 0;
            obs_rd[s]  = 32'h0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset HREADY", {31'b0, rdy_o[1]}, 32'h1);
        chk("reset HRESP", {31'b0, rsp_o[1]}, 32'h0);
        chk("reset HRDATA", rd_o[1], 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle(0, 1);

        // Zero-wait back-to-back write then read of the same word.
        lowcyc[0] = 0;
        issue(0, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF);
        issue(0, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        idle(0, 2);
        chk("raw readback", obs_rd[0], 32'hDEAD_BEEF);
        chk("raw no stall", lowcyc[0], 32'd0);

        // Misaligned / out-of-range read.
        errcyc[0] = 0;
        lastrun[0] = 0;
        issue(0, HTRANS_NONSEQ, 32'h4002, 1'b0, HSIZE_WORD, 32'h0);
        idle(0, 3);
        chk("dut0 err cycles", errcyc[0], 32'd2);
        chk("dut0 err low run", lastrun[0], 32'd1);

        // Out-of-range and bad-size writes must leave word 0 untouched.
        issue(0, HTRANS_NONSEQ, 32'h0, 1'b1, HSIZE_WORD, 32'hA5A5_A5A5);
        issue(0, HTRANS_NONSEQ, BASE_ADDR + 4 * MEM_DEPTH, 1'b1, HSIZE_WORD, 32'h5555_5555);
        issue(0, HTRANS_NONSEQ, 32'h0, 1'b1, 3'b001, 32'h6666_6666);
        issue(0, HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
        idle(0, 3);
        chk("word0 unchanged", obs_rd[0], 32'hA5A5_A5A5);

        // Burst with BUSY/IDLE gaps, then read back.
        issue(0, HTRANS_NONSEQ, 32'h40, 1'b1, HSIZE_WORD, 32'h0000_0100);
        issue(0, HTRANS_BUSY,   32'h44, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF);
        issue(0, HTRANS_SEQ,    32'h44, 1'b1, HSIZE_WORD, 32'h0000_0101);
        issue(0, HTRANS_IDLE,   32'h48, 1'b1, HSIZE_WORD, 32'hEEEE_EEEE);
        issue(0, HTRANS_SEQ,    32'h48, 1'b1, HSIZE_WORD, 32'h0000_0102);
        issue(0, HTRANS_SEQ,    32'h4C, 1'b1, HSIZE_WORD, 32'h0000_0103);
        issue(0, HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD, 32'h0);
        issue(0, HTRANS_SEQ,    32'h44, 1'b0, HSIZE_WORD, 32'h0);
        issue(0, HTRANS_SEQ,    32'h48, 1'b0, HSIZE_WORD, 32'h0);
        issue(0, HTRANS_SEQ,    32'h4C, 1'b0, HSIZE_WORD, 32'h0);
        idle(0, 3);
        chk("burst last word", obs_rd[0], 32'h0000_0103);

        // Three wait states.
        issue(1, HTRANS_NONSEQ, 32'h20, 1'b1, HSIZE_WORD, 32'hCAFE_F00D);
        idle(1, 6);
        lastrun[1] = 0;
        issue(1, HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD, 32'h0);
        idle(1, 6);
        chk("ws3 wait length", lastrun[1], 32'd3);
        chk("ws3 read data", obs_rd[1], 32'hCAFE_F00D);
        issue(1, HTRANS_NONSEQ, 32'h24, 1'b1, HSIZE_WORD, 32'h1234_5678);
        issue(1, HTRANS_NONSEQ, 32'h24, 1'b0, HSIZE_WORD, 32'h0);
        idle(1, 6);
        chk("ws3 write 0x24", obs_rd[1], 32'h1234_5678);

        errcyc[1] = 0;
        lastrun[1] = 0;
        issue(1, HTRANS_NONSEQ, 32'h4002, 1'b0, HSIZE_WORD, 32'h0);
        idle(1, 4);
        chk("dut1 err cycles", errcyc[1], 32'd2);
        chk("dut1 err low run", lastrun[1], 32'd1);

        // Reset during the second wait cycle of a write aborts it.
        issue(1, HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD, 32'h1111_2222);
        idle(1, 6);
        issue(1, HTRANS_NONSEQ, 32'h30, 1'b1, HSIZE_WORD, 32'h9999_8888);
        idle(1, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post-reset HREADY", {31'b0, rdy_o[1]}, 32'h1);
        chk("post-reset HRESP", {31'b0, rsp_o[1]}, 32'h0);
        chk("post-reset HRDATA", rd_o[1], 32'h0);
        issue(1, HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD, 32'h0);
        idle(1, 6);
        chk("aborted write", obs_rd[1], 32'h1111_2222);

        idle(0, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
